// File: rtl/mic_sched_pkg.sv
// ---------------------------------------------------------------------------
// mic_sched_pkg
// Shared definitions for the microphone FIR scheduler:
//   - scheduler state encoding (IDLE, WAIT_ALL, ISSUE)
//   - default values for channel count, sample width, decimation,
//     frame wait budget and FIR in-flight limit
//   - clog2_min1(): counter width helper that never returns zero bits
// ---------------------------------------------------------------------------
package mic_sched_pkg;

   localparam int N_DEF        = 3;
   localparam int W_DEF        = 16;
   localparam int DECIM_DEF    = 2;
   localparam int WAIT_MAX_DEF = 64;
   localparam int MAX_OUT_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ALL = 2'd1,
      ISSUE    = 2'd2
   } sched_state_e;

   // Width of a counter that must hold values 0..v-1; at least one bit.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/mic_decimator.sv
// ---------------------------------------------------------------------------
// mic_decimator
// Per-channel decimator on the FIR result stream. Every DECIM-th result
// routed to this channel is registered on data_out with a one-cycle
// valid_out strobe; the other results only advance the phase counter.
// Ports:
//   clk_in, rst_in   : clock, asynchronous active-high reset
//   result_valid_in  : a FIR result belonging to this channel
//   result_in        : FIR result data (W-bit two's complement)
//   data_out         : most recent decimated sample
//   valid_out        : one-cycle strobe, one cycle after the kept result
// ---------------------------------------------------------------------------
module mic_decimator
   import mic_sched_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DECIM = DECIM_DEF
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         result_valid_in,
   input  logic [W-1:0] result_in,
   output logic [W-1:0] data_out,
   output logic         valid_out
);

   localparam int CW = clog2_min1(DECIM);

   logic [CW-1:0] dcnt;

   // Phase counter, output register and strobe.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         dcnt      <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (result_valid_in) begin
            if (dcnt == CW'(DECIM - 1)) begin
               dcnt      <= '0;
               data_out  <= result_in;
               valid_out <= 1'b1;
            end else begin
               dcnt <= dcnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/mic_fir_scheduler.sv
// ---------------------------------------------------------------------------
// mic_fir_scheduler
// Time-multiplexes N microphone channels through one shared interleaved FIR.
// Incoming per-channel samples are held, snapshotted as a frame (all
// channels present, or a timeout after channel 0 arrived), issued to the FIR
// in channel order over valid/ready, and the FIR results are demultiplexed
// back to channels and decimated by DECIM.
// Ports:
//   clk_in, rst_in       : clock, asynchronous active-high reset
//   sample_in            : packed samples, channel i at [i*W +: W]
//   sample_valid_in      : per-channel one-cycle sample strobe
//   fir_tdata_out        : sample to FIR
//   fir_tvalid_out       : FIR input valid (held until fir_tready_in)
//   fir_tready_in        : FIR input ready
//   fir_result_in        : FIR output data
//   fir_result_valid_in  : FIR output valid, no backpressure
//   chan_data_out        : latest decimated sample per channel
//   chan_valid_out       : per-channel one-cycle output strobe
//   overrun_out          : sticky, a sample was overwritten before framing
//   stale_out            : sticky, a channel was reused in a timed-out frame
//   seq_error_out        : sticky, a FIR result arrived with none outstanding
//   busy_out             : scheduler is not idle
// ---------------------------------------------------------------------------
module mic_fir_scheduler
   import mic_sched_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int W        = W_DEF,
   parameter int DECIM    = DECIM_DEF,
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int MAX_OUT  = MAX_OUT_DEF
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic [N*W-1:0] sample_in,
   input  logic [N-1:0]   sample_valid_in,
   output logic [W-1:0]   fir_tdata_out,
   output logic           fir_tvalid_out,
   input  logic           fir_tready_in,
   input  logic [W-1:0]   fir_result_in,
   input  logic           fir_result_valid_in,
   output logic [N*W-1:0] chan_data_out,
   output logic [N-1:0]   chan_valid_out,
   output logic [N-1:0]   overrun_out,
   output logic [N-1:0]   stale_out,
   output logic           seq_error_out,
   output logic           busy_out
);

   localparam int TW = clog2_min1(WAIT_MAX);
   localparam int KW = clog2_min1(N);
   localparam int OW = $clog2(MAX_OUT + 1);

   sched_state_e  state;
   sched_state_e  state_next;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_next;
   logic [KW-1:0] k;
   logic [KW-1:0] k_next;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_next;
   logic [KW-1:0] rc;

   logic [W-1:0]  hold  [N];
   logic [W-1:0]  frame [N];
   logic [N-1:0]  pending;

   logic          snapshot;
   logic          handshake;
   logic          result_ok;
   logic          tvalid_next;
   logic [W-1:0]  tdata_next;
   logic          busy_next;

   assign handshake = fir_tvalid_out & fir_tready_in;
   // A result is only attributed to a channel when something is in flight.
   assign result_ok = fir_result_valid_in & (outstanding != '0);

   // In-flight FIR sample count: issue adds one, accepted result removes one.
   always_comb begin
      outstanding_next = outstanding;
      if (handshake && !result_ok) begin
         outstanding_next = outstanding + OW'(1);
      end else if (!handshake && result_ok) begin
         outstanding_next = outstanding - OW'(1);
      end else begin
         outstanding_next = outstanding;
      end
   end

   // Scheduler next-state logic and frame snapshot decision.
   always_comb begin
      state_next = state;
      timer_next = timer;
      k_next     = k;
      snapshot   = 1'b0;
      case (state)
         IDLE: begin
            if (&pending) begin
               snapshot   = 1'b1;
               state_next = ISSUE;
               k_next     = '0;
            end else if (pending[0]) begin
               state_next = WAIT_ALL;
               timer_next = '0;
            end else begin
               state_next = IDLE;
            end
         end
         WAIT_ALL: begin
            if ((&pending) || (timer == TW'(WAIT_MAX - 1))) begin
               snapshot   = 1'b1;
               state_next = ISSUE;
               k_next     = '0;
            end else begin
               timer_next = timer + TW'(1);
            end
         end
         ISSUE: begin
            if (handshake) begin
               if (k == KW'(N - 1)) begin
                  state_next = IDLE;
                  k_next     = '0;
               end else begin
                  k_next = k + KW'(1);
               end
            end else begin
               k_next = k;
            end
         end
         default: begin
            state_next = IDLE;
            k_next     = '0;
         end
      endcase
   end

   // Next values of the registered FIR interface. While valid is high and
   // no handshake happens the in-flight count cannot rise, so valid stays
   // asserted until accepted. At a snapshot the frame is not loaded yet, so
   // channel 0 data comes straight from its holding register.
   always_comb begin
      tvalid_next = 1'b0;
      tdata_next  = '0;
      busy_next   = (state_next != IDLE);
      if (state_next == ISSUE) begin
         tvalid_next = (outstanding_next < OW'(MAX_OUT));
         if (snapshot) begin
            tdata_next = hold[0];
         end else begin
            tdata_next = frame[k_next];
         end
      end else begin
         tvalid_next = 1'b0;
         tdata_next  = '0;
      end
   end

   // State, counters and registered FIR/busy outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= IDLE;
         timer          <= '0;
         k              <= '0;
         outstanding    <= '0;
         fir_tvalid_out <= 1'b0;
         fir_tdata_out  <= '0;
         busy_out       <= 1'b0;
      end else begin
         state          <= state_next;
         timer          <= timer_next;
         k              <= k_next;
         outstanding    <= outstanding_next;
         fir_tvalid_out <= tvalid_next;
         fir_tdata_out  <= tdata_next;
         busy_out       <= busy_next;
      end
   end

   // Holding stage. A sample landing in the snapshot cycle misses this frame
   // but stays pending for the next one, and is not counted as an overrun.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < N; i++) begin
            hold[i] <= '0;
         end
         pending     <= '0;
         overrun_out <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sample_valid_in[i]) begin
               hold[i] <= sample_in[i*W +: W];
            end
            if (snapshot) begin
               pending[i] <= sample_valid_in[i];
            end else if (sample_valid_in[i]) begin
               pending[i] <= 1'b1;
               if (pending[i]) begin
                  overrun_out[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Frame registers. A channel without a fresh sample keeps the value it
   // already had in hold (the previous frame's value) and is flagged stale.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < N; i++) begin
            frame[i] <= '0;
         end
         stale_out <= '0;
      end else if (snapshot) begin
         for (int i = 0; i < N; i++) begin
            frame[i] <= hold[i];
            if (!pending[i]) begin
               stale_out[i] <= 1'b1;
            end
         end
      end
   end

   // Result channel pointer and sequencing error flag.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rc            <= '0;
         seq_error_out <= 1'b0;
      end else begin
         if (result_ok) begin
            rc <= (rc == KW'(N - 1)) ? '0 : rc + KW'(1);
         end
         if (fir_result_valid_in && (outstanding == '0)) begin
            seq_error_out <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_dec
      mic_decimator #(
         .W     (W),
         .DECIM (DECIM)
      ) u_dec (
         .clk_in          (clk_in),
         .rst_in          (rst_in),
         .result_valid_in (result_ok && (rc == KW'(g))),
         .result_in       (fir_result_in),
         .data_out        (chan_data_out[g*W +: W]),
         .valid_out       (chan_valid_out[g])
      );
   end

endmodule

// File: doc/mic_fir_scheduler.md
Name: mic_fir_scheduler

Overview:
Time-multiplexes N I2S mic channels through one shared anti-alias FIR configured for N interleaved channels.
- Collects per-mic samples and snapshots them as a frame.
- Issues the frame to the FIR in strict channel order 0..N-1 over a valid/ready handshake.
- Demuxes FIR results back to channels and decimates each channel by DECIM.
- Sits between the i2s receivers and the downstream consumers (sos_dist_calculator, pdm mux).

Parameters:
N, 3, number of mic channels
W, 16, sample width (signed)
DECIM, 2, per-channel decimation factor (>=1)
WAIT_MAX, 64, cycles to wait for a full frame after channel 0 arrives
MAX_OUT, 8, maximum FIR samples in flight

Ports:
clk_in  in  1  audio clock (98.3 MHz)
rst_in  in  1  reset; asynchronous, active-high
sample_in  in  N*W  packed mic samples, channel i at [i*W +: W]
sample_valid_in  in  N  one-cycle strobe per channel
fir_tdata_out  out  W  sample to FIR
fir_tvalid_out  out  1  FIR input valid
fir_tready_in  in  1  FIR input ready
fir_result_in  in  W  FIR output data
fir_result_valid_in  in  1  FIR output valid (no backpressure)
chan_data_out  out  N*W  latest decimated sample per channel
chan_valid_out  out  N  one-cycle strobe per channel
overrun_out  out  N  sticky: sample overwritten before framing
stale_out  out  N  sticky: channel repeated in a timed-out frame
seq_error_out  out  1  sticky: FIR result with nothing outstanding
busy_out  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_in=1): all outputs 0; all holding registers, frame registers and pending flags 0; state IDLE; outstanding=0; result channel=0; decimation counters 0.
- Holding stage, per channel:
  - sample_valid_in[i] loads hold[i] and sets pending[i].
  - If pending[i] is already set and the same cycle is not a frame snapshot, set overrun_out[i].
- State machine:
  - IDLE: if all pending bits set, snapshot, go to ISSUE. Else if pending[0] is set, go to WAIT_ALL with timer=0.
  - WAIT_ALL: timer increments each cycle. When all pending bits set, or timer==WAIT_MAX-1, snapshot and go to ISSUE.
  - ISSUE: k=0..N-1. fir_tvalid_out=1 with fir_tdata_out=frame[k], held stable until fir_tready_in. On handshake, k++. Handshake at k=N-1 returns to IDLE.
- Snapshot:
  - frame[i]=hold[i] for every i; all pending bits cleared.
  - A channel that is not pending reuses its previous frame value and sets stale_out[i].
  - A sample arriving in the snapshot cycle is lost to this frame: hold[i] is loaded and pending[i] stays set for the next frame; no overrun is flagged.
- Flow limit:
  - fir_tvalid_out is asserted only while outstanding<MAX_OUT.
  - Once asserted, tvalid may not drop before the handshake.
- Outstanding counter:
  - Handshake alone: +1. Result alone: -1. Both in the same cycle: unchanged.
  - Result while outstanding==0: ignored, seq_error_out set, result channel not advanced.
- Result demux:
  - Each accepted result belongs to channel rc; rc then wraps 0..N-1.
  - dcnt[rc] increments on each result. When dcnt[rc]==DECIM-1: chan_data_out[rc] <= fir_result_in, chan_valid_out[rc] pulses 1 cycle, dcnt[rc] wraps to 0.
  - Latency: 1 cycle from fir_result_valid_in to chan_valid_out.
- Width: samples are passed unmodified as W-bit two's complement.
- Reset mid-ISSUE: tvalid drops immediately. The FIR must be reset with the same rst_in so interleave alignment restarts at channel 0.

Decomposition:
- Package mic_sched_pkg holds the state enum (IDLE, WAIT_ALL, ISSUE) and the default constants N, W, DECIM.
- One natural sub-module: mic_decimator (one per channel, generate loop). It owns the DECIM counter and the output register/strobe.
- Holding/frame logic and the FSM stay in the top.

Test Plan:
- All 3 channels strobe together with values 0x0100, 0x0200, 0x0300, tready=1 -> FIR sees 0x0100, 0x0200, 0x0300 on consecutive cycles; busy_out low afterwards.
- Loopback FIR (result = input, 5-cycle delay), two frames, DECIM=2 -> each channel's chan_valid_out pulses once, carrying the second frame's value.
- Only channel 0 strobes; 64 cycles elapse -> frame issued with previous values for ch1/ch2; stale_out=3'b110.
- Channel 1 strobes twice while IDLE waits on ch2 -> overrun_out[1]=1; frame carries the second ch1 value.
- tready held low 10 cycles during ISSUE k=1 -> tvalid stays high and tdata stable; issue resumes with ch1, then ch2.
- fir_result_valid_in pulse right after reset -> seq_error_out=1; no chan_valid_out pulse.
